ex_dispatch_arbiter: RTL and testbench
======================================

Name: ex_dispatch_arbiter

Overview:
- Shares one execution-unit dispatch port among NUM_REQS issue slices. Each slice presents an independent valid/ready stream of dispatch beats carrying sop/eop framing.
- Arbitration is round-robin per packet. Once a multi-beat packet starts (sop without eop), the grant stays locked to that requester until its eop beat is accepted.
- Sits between the per-slice dispatch buffers and a shared functional unit. Output passes through one pipeline register.

Parameters:
- NUM_REQS, 4, number of requesting issue slices (>=1).
- DATAW, 64, dispatch payload width, excluding sop/eop.
- REQ_SEL_W, max(1, clog2(NUM_REQS)), width of the requester index (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQS  per-requester beat valid
- req_data  in  NUM_REQS*DATAW  per-requester payload; requester i occupies bits [i*DATAW +: DATAW]
- req_sop  in  NUM_REQS  first beat of packet
- req_eop  in  NUM_REQS  last beat of packet
- req_ready  out  NUM_REQS  beat accepted from requester i
- out_valid  out  1  registered beat valid
- out_data  out  DATAW  registered payload
- out_sop  out  1  registered sop
- out_eop  out  1  registered eop
- out_sel  out  REQ_SEL_W  source requester index of the current output beat
- out_ready  in  1  downstream accept
- locked  out  1  high while a packet is in progress (state LOCKED)

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, lock_idx=0.
  - out_valid=0; out_data/out_sop/out_eop/out_sel=0; locked=0.
  - req_ready is all zeros while reset is high.
- Output stage: single register.
  - stage_ready = ~out_valid | out_ready.
  - Full throughput: a new beat can be loaded in the same cycle the held beat drains.
  - Latency from request handshake to out_valid is 1 cycle.
- Grant selection (combinational):
  - IDLE: grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQS.
  - LOCKED: grant = lock_idx, considered only if req_valid[lock_idx]. Other requesters are never granted, even if the locked requester is idle.
- req_ready[i] = (i == grant) & grant_valid & stage_ready & ~reset. At most one bit is high.
  - req_ready must not depend on req_valid of the same index beyond grant selection.
- fire = grant_valid & stage_ready. On fire, the output register loads data/sop/eop of the granted requester and out_sel=grant.
- FSM:
  - IDLE -> LOCKED: on fire with sop=1, eop=0; lock_idx <= grant.
  - IDLE -> IDLE: on fire with eop=1 (single-beat packet); rr_ptr <= (grant+1) mod NUM_REQS.
  - LOCKED -> LOCKED: on fire with eop=0.
  - LOCKED -> IDLE: on fire with eop=1; rr_ptr <= (lock_idx+1) mod NUM_REQS.
  - A beat in IDLE with sop=0 is a protocol violation (simulation assertion). It is handled like sop=1.
  - A beat with sop=1 in LOCKED is a protocol violation (assertion). It is treated as a continuation beat.
- rr_ptr wraps from NUM_REQS-1 to 0. When NUM_REQS is not a power of two, the modulo uses explicit compare, not truncation.
- Downstream stall (out_ready=0 with out_valid=1): output register and FSM hold, req_ready is all zeros, and there is no grant change mid-stall.
- NUM_REQS=1: rr_ptr is constant 0 and out_sel=0. The lock logic is kept so the locked output stays consistent.
- Reset mid-packet: the packet is abandoned. There is no residual lock, and the next grant after reset starts from requester 0.
- locked is a registered output (state==LOCKED).

Decomposition:
- Shared package: no new typedefs. Use the existing clog2/max helpers for REQ_SEL_W. Add a localparam for the FSM encoding (IDLE=0, LOCKED=1) inside the module.
- One sub-module: rr_priority_pick. Combinational, it takes (valid vector, rr_ptr) and returns (index, found). It is reusable by other dispatch and commit arbiters.

Test Plan:
- NUM_REQS=4; requesters 0–3 each hold one single-beat packet (sop=eop=1, data=0x10+i), out_ready=1 -> out_sel sequence 0,1,2,3 on consecutive cycles; out_data 0x10..0x13; locked stays 0.
- Req1 sends a 3-beat packet (sop, mid, eop) while req0 and req2 are continuously valid -> the three req1 beats are contiguous on the output, locked=1 for two cycles, and the next grant is req2.
- Locked req1 deasserts valid for 2 cycles mid-packet while req0 is valid -> req_ready all zeros, out_valid drops after draining, and req0 is not granted until req1's eop is accepted.
- out_ready held 0 for 5 cycles with out_valid=1 -> out_data/out_sel stable, req_ready=0 throughout, and no beat lost or duplicated when out_ready returns.
- Assert reset while locked on req3 mid-packet -> out_valid=0 and locked=0 immediately (async). After release, with all requesters valid, the first out_sel is 0.
- Random valid/ready/packet lengths 1–4 beats over 10k cycles, with a scoreboard per requester -> per-source beat order preserved, packets never interleaved, and no requester starved beyond NUM_REQS packets.

Source files
------------

// File: rtl/ex_dispatch_arbiter_pkg.sv
// Shared sizing helpers for the dispatch/commit arbiters.
// Pure elaboration-time functions; no logic, no latency, no flow control.
package ex_dispatch_arbiter_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin picker: first valid index at or after i_ptr, wrapping modulo N.
// Purely combinational; no backpressure of its own.
module rr_priority_pick
  import ex_dispatch_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  // Distance from the pointer is computed by explicit compare so non-power-of-two N wraps correctly.
  always_comb begin
    int w_best;
    int w_dist;
    o_idx   = '0;
    o_found = 1'b0;
    w_best  = N;
    w_dist  = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + N - int'(i_ptr));
      if (i_valid[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_idx   = SEL_W'(j);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_dispatch_arbiter.sv
// Packet-locked round-robin mux of NUM_REQS dispatch streams onto one registered port.
// One-cycle latency, full throughput; out_ready low freezes the output register and all req_ready.
module ex_dispatch_arbiter
  import ex_dispatch_arbiter_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int DATAW     = 64,
  parameter int REQ_SEL_W = max_int(1, clog2(NUM_REQS))
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_sop,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [REQ_SEL_W-1:0]      out_sel,
  input  logic                      out_ready,
  output logic                      locked
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic                 r_state;
  logic [REQ_SEL_W-1:0] r_rr_ptr;
  logic [REQ_SEL_W-1:0] r_lock_idx;
  logic                 r_out_valid;
  logic [DATAW-1:0]     r_out_data;
  logic                 r_out_sop;
  logic                 r_out_eop;
  logic [REQ_SEL_W-1:0] r_out_sel;

  logic [REQ_SEL_W-1:0] w_pick_idx;
  logic                 w_pick_found;
  logic [REQ_SEL_W-1:0] w_grant;
  logic                 w_grant_valid;
  logic [DATAW-1:0]     w_grant_data;
  logic                 w_grant_sop;
  logic                 w_grant_eop;
  logic                 w_stage_ready;
  logic                 w_fire;
  logic [REQ_SEL_W-1:0] w_next_ptr;

  rr_priority_pick #(
    .N    (NUM_REQS),
    .SEL_W(REQ_SEL_W)
  ) u_pick (
    .i_valid(req_valid),
    .i_ptr  (r_rr_ptr),
    .o_idx  (w_pick_idx),
    .o_found(w_pick_found)
  );

  // While locked the picker is ignored: an idle owner blocks everyone else.
  always_comb begin
    w_grant       = (r_state == ST_LOCKED) ? r_lock_idx : w_pick_idx;
    w_grant_valid = 1'b0;
    w_grant_data  = '0;
    w_grant_sop   = 1'b0;
    w_grant_eop   = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_grant == REQ_SEL_W'(i)) begin
        w_grant_valid = req_valid[i];
        w_grant_data  = req_data[i*DATAW +: DATAW];
        w_grant_sop   = req_sop[i];
        w_grant_eop   = req_eop[i];
      end
    end
  end

  assign w_stage_ready = ~r_out_valid | out_ready;
  assign w_fire        = w_grant_valid & w_stage_ready;
  assign w_next_ptr    = (w_grant == REQ_SEL_W'(NUM_REQS - 1)) ? '0 : (w_grant + 1'b1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = (w_grant == REQ_SEL_W'(i)) & w_grant_valid & w_stage_ready & ~reset;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_lock_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_sop   <= w_grant_sop;
      r_out_eop   <= w_grant_eop;
      r_out_sel   <= w_grant;
      // A missing sop in IDLE still opens a packet; a stray sop while locked is a continuation.
      if (r_state == ST_IDLE) begin
        if (w_grant_eop) begin
          r_rr_ptr <= w_next_ptr;
        end else begin
          r_state    <= ST_LOCKED;
          r_lock_idx <= w_grant;
        end
      end else if (w_grant_eop) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= w_next_ptr;
      end
    end else if (w_stage_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign out_sel   = r_out_sel;
  assign locked    = r_state;

  a_idle_needs_sop: assert property (@(posedge clk) disable iff (reset)
    (w_fire && (r_state == ST_IDLE)) |-> w_grant_sop);
  a_locked_no_sop: assert property (@(posedge clk) disable iff (reset)
    (w_fire && (r_state == ST_LOCKED)) |-> !w_grant_sop);
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

endmodule

// File: tb/tb_ex_dispatch_arbiter.sv
// Directed + random scoreboard bench for ex_dispatch_arbiter (NUM_REQS=4, DATAW=64).
module tb_ex_dispatch_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_sop;
  logic [NR-1:0]    req_eop;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_sop;
  logic             out_eop;
  logic [SW-1:0]    out_sel;
  logic             out_ready;
  logic             locked;

  ex_dispatch_arbiter #(.NUM_REQS(NR), .DATAW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_sop  (req_sop),
    .req_eop  (req_eop),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_sel  (out_sel),
    .out_ready(out_ready),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int      n_chk = 0;
  int      n_fail = 0;
  beat_t   exp_q[$];
  beat_t   tx_q[NR][$];
  beat_t   src_q[NR][$];
  logic [NR-1:0] en = '1;
  logic [NR-1:0] hs = '0;
  bit      rnd_mode = 1'b0;
  bit      in_pkt = 1'b0;
  logic [SW-1:0] cur_src = '0;
  int      wait_cnt[NR];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int sel, input logic [63:0] d, input logic sop, input logic eop);
    beat_t b;
    b.sel  = SW'(sel);
    b.data = d;
    b.sop  = sop;
    b.eop  = eop;
    return b;
  endfunction

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0) || out_valid;
    for (int i = 0; i < NR; i++) b = b || (tx_q[i].size() != 0) || (src_q[i].size() != 0);
    return b;
  endfunction

  // Push a beat to requester i and, in directed mode, its expected output in grant order elsewhere.
  task automatic send(input int i, input logic [63:0] d, input logic sop, input logic eop);
    tx_q[i].push_back(mk(i, d, sop, eop));
  endtask

  task automatic expect_beat(input int i, input logic [63:0] d, input logic sop, input logic eop);
    exp_q.push_back(mk(i, d, sop, eop));
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy() && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_drain"}, 72'(t < 400), 72'(1));
    exp_q.delete();
  endtask

  // Requester model: holds each beat until it sees the handshake; gating only ever applies mid-packet.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_sop   = '0;
    req_eop   = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
        if (tx_q[i].size() > 0 && (en[i] || tx_q[i][0].sop)) begin
          req_valid[i]           = 1'b1;
          req_data[i*DW +: DW]   = tx_q[i][0].data;
          req_sop[i]             = tx_q[i][0].sop;
          req_eop[i]             = tx_q[i][0].eop;
        end else begin
          req_valid[i] = 1'b0;
          req_sop[i]   = 1'b0;
          req_eop[i]   = 1'b0;
        end
      end
    end
  end

  // Monitor: every accepted output beat is checked against the scoreboard.
  initial begin
    beat_t got;
    int    s;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        got = {out_sel, out_data, out_sop, out_eop};
        s   = int'(out_sel);
        if (!rnd_mode) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", got, $time);
          end else begin
            chk("beat", 72'(got), 72'(exp_q.pop_front()));
          end
        end else begin
          if (src_q[s].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_src_beat: got %0h expected none at %0t", got, $time);
          end else begin
            chk("src_order", 72'(got), 72'(src_q[s].pop_front()));
          end
          if (in_pkt) chk("no_interleave", 72'(out_sel), 72'(cur_src));
          in_pkt  = !got.eop;
          cur_src = out_sel;
          if (got.sop) wait_cnt[s] = 0;
          if (got.eop) begin
            for (int j = 0; j < NR; j++) begin
              if (j != s && req_valid[j]) begin
                wait_cnt[j]++;
                chk("no_starve", 72'(wait_cnt[j] > NR), 72'(0));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int t;
    int len;
    int seq[NR];
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      wait_cnt[i] = 0;
      seq[i]      = 0;
    end

    // Reset state, with all four single-beat packets already waiting.
    for (int i = 0; i < NR; i++) begin
      send(i, 64'h10 + 64'(i), 1'b1, 1'b1);
      expect_beat(i, 64'h10 + 64'(i), 1'b1, 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 72'(req_ready), 72'(0));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_out_data", 72'(out_data), 72'(0));
    chk("rst_out_sel", 72'({out_sel, out_sop, out_eop}), 72'(0));
    chk("rst_locked", 72'(locked), 72'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Single-beat round robin: 0,1,2,3 back to back.
    @(negedge clk);
    chk("t1_latency", 72'(out_valid), 72'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_contig", 72'(out_valid), 72'(1));
      chk("t1_locked", 72'(locked), 72'(0));
    end
    wait_idle("t1");

    // 3-beat packet on req1 with req0/req2 busy; rr_ptr=0 here.
    send(0, 64'h30, 1'b1, 1'b1);
    send(0, 64'h31, 1'b1, 1'b1);
    send(1, 64'h21, 1'b1, 1'b0);
    send(1, 64'h22, 1'b0, 1'b0);
    send(1, 64'h23, 1'b0, 1'b1);
    send(2, 64'h50, 1'b1, 1'b1);
    send(2, 64'h51, 1'b1, 1'b1);
    expect_beat(0, 64'h30, 1'b1, 1'b1);
    expect_beat(1, 64'h21, 1'b1, 1'b0);
    expect_beat(1, 64'h22, 1'b0, 1'b0);
    expect_beat(1, 64'h23, 1'b0, 1'b1);
    expect_beat(2, 64'h50, 1'b1, 1'b1);
    expect_beat(0, 64'h31, 1'b1, 1'b1);
    expect_beat(2, 64'h51, 1'b1, 1'b1);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (locked) cnt++;
    end
    chk("t2_locked_cycles", 72'(cnt), 72'(2));
    wait_idle("t2");

    // Locked req1 goes quiet for 2 cycles while req0 waits; rr_ptr=3 here.
    send(1, 64'h61, 1'b1, 1'b0);
    send(1, 64'h62, 1'b0, 1'b0);
    send(1, 64'h63, 1'b0, 1'b1);
    expect_beat(1, 64'h61, 1'b1, 1'b0);
    expect_beat(1, 64'h62, 1'b0, 1'b0);
    expect_beat(1, 64'h63, 1'b0, 1'b1);
    expect_beat(0, 64'h40, 1'b1, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!locked && t < 20);
    chk("t3_lock_seen", 72'(locked), 72'(1));
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    send(0, 64'h40, 1'b1, 1'b1);
    @(negedge clk);
    chk("t3_ready_gap1", 72'(req_ready), 72'(0));
    @(negedge clk);
    chk("t3_ready_gap2", 72'(req_ready), 72'(0));
    chk("t3_out_drained", 72'(out_valid), 72'(0));
    chk("t3_still_locked", 72'(locked), 72'(1));
    @(posedge clk);
    #1 en[1] = 1'b1;
    wait_idle("t3");

    // Downstream stall for 5 cycles; rr_ptr=1 here.
    out_ready = 1'b0;
    for (int i = 1; i < NR; i++) begin
      send(i, 64'h70 + 64'(i), 1'b1, 1'b1);
      expect_beat(i, 64'h70 + 64'(i), 1'b1, 1'b1);
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 20);
    repeat (5) begin
      @(negedge clk);
      chk("t4_stall_data", 72'({out_valid, out_sel, out_data}), {5'd0, 1'b1, 2'd1, 64'h71});
      chk("t4_stall_ready", 72'(req_ready), 72'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("t4");

    // Reset while req3 holds the lock; afterwards arbitration restarts at requester 0.
    out_ready = 1'b0;
    send(3, 64'h81, 1'b1, 1'b0);
    send(3, 64'h82, 1'b0, 1'b0);
    send(3, 64'h83, 1'b0, 1'b0);
    send(3, 64'h84, 1'b0, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!locked && t < 20);
    chk("t5_locked_on_3", 72'({locked, out_sel}), 72'({1'b1, 2'd3}));
    #2 reset = 1'b1;
    #1;
    chk("t5_async_out_valid", 72'(out_valid), 72'(0));
    chk("t5_async_locked", 72'(locked), 72'(0));
    chk("t5_async_ready", 72'(req_ready), 72'(0));
    for (int i = 0; i < NR; i++) tx_q[i].delete();
    for (int i = 0; i < NR; i++) begin
      send(i, 64'h90 + 64'(i), 1'b1, 1'b1);
      expect_beat(i, 64'h90 + 64'(i), 1'b1, 1'b1);
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle("t5");

    // Random traffic: per-source ordering, no interleave, bounded waiting.
    rnd_mode = 1'b1;
    in_pkt   = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        en[i] = ($urandom_range(0, 3) != 0);
        if (tx_q[i].size() == 0 && $urandom_range(0, 2) != 0) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            tx_q[i].push_back(mk(i, {8'(i), 24'(seq[i]), 32'(b)}, b == 0, b == len - 1));
            src_q[i].push_back(mk(i, {8'(i), 24'(seq[i]), 32'(b)}, b == 0, b == len - 1));
          end
          seq[i]++;
        end
      end
    end
    en        = '1;
    out_ready = 1'b1;
    wait_idle("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
